pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Central stall/flush/redirect sequencer for the 5-stage core. Watches the ID-stage decode outputs
//  (rs1/rs2, syscall/break/mret) and EX/MEM status. Generates stage stalls, bubbles, PC-select and
//  trap (EPC/cause) updates. Contains a trap FSM that drains older instructions before redirecting.
// PARAMETERS
//  DRAIN_CYCLES  3   non-frozen cycles spent in DRAIN before redirect (EX+MEM+WB depth)
// PORTS
//  clk              in   1   core clock
//  rst              in   1   asynchronous reset, active-high
//  id_rs1,id_rs2    in   5   source regs of instruction in ID
//  id_pc            in   32  PC of instruction in ID
//  id_syscall       in   1   ID holds ECALL
//  id_break         in   1   ID holds EBREAK
//  id_mret          in   1   ID holds MRET
//  ex_rd            in   5   dest reg of instruction in EX
//  ex_mem_read      in   1   EX instruction is a load
//  ex_branch_taken  in   1   EX resolved a taken branch/jump
//  dmem_req         in   1   MEM stage has an outstanding data access
//  dmem_ready       in   1   data memory completes access this cycle
//  if_stall,id_stall  out 1  hold PC / IF-ID register
//  ex_stall,mem_stall out 1  hold ID-EX / EX-MEM register
//  id_flush,ex_flush  out 1  replace IF-ID / ID-EX content with NOP next edge
//  pc_sel           out  2   00 seq, 01 branch target, 10 trap vector, 11 EPC
//  epc_we           out  1   write epc/mcause this cycle
//  epc              out  32  captured PC of trapping instruction (registered)
//  mcause           out  4   11 = ECALL, 3 = EBREAK (registered)
//  trap_busy        out  1   FSM not in RUN
// BEHAVIOUR
//  Reset: state=RUN, drain_cnt=0, epc=0, mcause=0, pend_kind=0; all outputs 0, pc_sel=00.
//  mem_freeze = dmem_req & ~dmem_ready. Highest priority: all four stalls=1, flushes=0, pc_sel=00,
//   epc_we=0, FSM and drain_cnt hold. All rules below apply only when mem_freeze=0.
//  load_use = ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
//  State RUN, evaluated in this priority order:
//   1. ex_branch_taken: pc_sel=01, id_flush=1, ex_flush=1. Any trap/load_use in ID is discarded (wrong path).
//   2. load_use: if_stall=id_stall=1, ex_flush=1 for exactly 1 cycle. The load advances, so it clears next cycle.
//   3. id_syscall|id_break|id_mret:
//      Latch pend_kind. For syscall/break, also latch epc<=id_pc and mcause. Go to DRAIN, drain_cnt<=0.
//      If several are asserted, priority is syscall > break > mret.
//  DRAIN: if_stall=id_stall=1, ex_flush=1 (bubbles fill behind older instrs); drain_cnt++ per cycle.
//   When drain_cnt==DRAIN_CYCLES-1 -> REDIRECT. ex_branch_taken is ignored here: only bubbles or older
//   non-branch instrs remain.
//  REDIRECT (1 cycle): id_flush=1, ex_flush=1.
//   pc_sel=10 with epc_we=1 for syscall/break; pc_sel=11 with epc_we=0 for mret. Then -> RUN.
//  Latency: trap detected in ID at cycle N -> redirect at N+DRAIN_CYCLES+1 (no freezes).
//  rd==0 never creates a hazard. Async rst at any point (incl. mid-DRAIN) returns to RUN, discards pend_kind.
//  epc/mcause change only on trap acceptance; they hold across mret.
// CONFIGURATION
//  PIPE_PERF_CNT_EN defined: adds outputs stall_cycles[31:0] and flush_events[31:0], both reset to 0.
//   stall_cycles +1 on any cycle with if_stall=1; flush_events +1 on any cycle with id_flush=1.
//   Both counters wrap at 2^32.
//  Undefined: these ports and counters do not exist; the rest of the behaviour is identical.
// STRUCTURE
//  Shared pipe_pkg.vh: PC_SEL_SEQ/BR/TRAP/EPC encodings, FSM state codes (RUN/DRAIN/REDIRECT),
//   MCAUSE_ECALL=11 / MCAUSE_EBREAK=3, pend_kind codes.
//  One sub-module: hazard_detect (combinational load_use compare). FSM and counters stay in pipeline_ctrl.
// TESTING
//  1. ex_mem_read=1, ex_rd=5, id_rs2=5 -> one cycle of if_stall=id_stall=ex_flush=1, then all 0. Repeat with ex_rd=0 -> no stall.
//  2. id_syscall=1, id_pc=0x100 -> 3 DRAIN cycles of stall+ex_flush, then pc_sel=10, epc_we=1,
//     epc=0x100, mcause=11; trap_busy low after.
//  3. id_break in the same cycle as ex_branch_taken=1 -> pc_sel=01, both flushes; no trap, epc unchanged.
//  4. id_mret during DRAIN with dmem_req=1, dmem_ready=0 for 4 cycles -> all stalls high, drain_cnt frozen;
//     redirect pc_sel=11 exactly 4 cycles later than in the unfrozen case.
//  5. rst pulsed mid-DRAIN -> all outputs 0 and trap_busy=0 immediately; the next idle cycle shows no redirect.
//  6. (PIPE_PERF_CNT_EN) the case 1 + case 2 sequence -> stall_cycles=4, flush_events=1.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Purpose : shared encodings for the pipeline stall/flush/trap sequencer.
// Latency : n/a (types, constants and one helper only).
// Backpressure: n/a.
package pipeline_ctrl_pkg;

  // Non-frozen cycles spent draining EX/MEM/WB before a trap redirect.
  localparam int DRAIN_CYCLES_DEF = 3;

  // pc_sel encodings
  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_BR   = 2'b01;
  localparam logic [1:0] PC_SEL_TRAP = 2'b10;
  localparam logic [1:0] PC_SEL_EPC  = 2'b11;

  // mcause values
  localparam logic [3:0] MCAUSE_ECALL  = 4'd11;
  localparam logic [3:0] MCAUSE_EBREAK = 4'd3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_DRAIN    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PEND_NONE   = 2'd0,
    PEND_ECALL  = 2'd1,
    PEND_EBREAK = 2'd2,
    PEND_MRET   = 2'd3
  } pend_t;

  // Trap kind seen in ID, with syscall > break > mret priority.
  function automatic pend_t pend_of(input logic syscall, input logic brk, input logic mret);
    if (syscall)   return PEND_ECALL;
    else if (brk)  return PEND_EBREAK;
    else if (mret) return PEND_MRET;
    else           return PEND_NONE;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Purpose : load-use hazard compare between the load in EX and the sources in ID.
// Latency : combinational, same cycle.
// Backpressure: none; result is consumed by the sequencer which raises the stalls.
// Ports   : id_rs1/id_rs2 (ID sources), ex_rd/ex_mem_read (EX load), load_use (hazard flag).
module pipeline_ctrl_hazard_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  // x0 is hardwired to zero, so a load targeting it never creates a dependency.
  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_ctrl.sv
// Purpose : stall/flush/redirect sequencer for the 5-stage core, including trap drain FSM.
// Latency : stalls/flushes/pc_sel combinational from state+inputs; trap in ID at cycle N
//           redirects at N+DRAIN_CYCLES+1 when no memory freeze intervenes.
// Backpressure: a pending data access (dmem_req & ~dmem_ready) freezes all four stages and the FSM.
// Ports   : clk/rst (async active-high); ID decode (id_rs1/2, id_pc, id_syscall/break/mret);
//           EX status (ex_rd, ex_mem_read, ex_branch_taken); MEM handshake (dmem_req/ready);
//           outputs: stage stalls, id/ex flushes, pc_sel, epc_we, epc, mcause, trap_busy.
// Option  : PIPE_PERF_CNT_EN adds stall_cycles / flush_events counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [31:0] id_pc,
  input  logic        id_syscall,
  input  logic        id_break,
  input  logic        id_mret,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ready,
  output logic        if_stall,
  output logic        id_stall,
  output logic        ex_stall,
  output logic        mem_stall,
  output logic        id_flush,
  output logic        ex_flush,
  output logic [1:0]  pc_sel,
  output logic        epc_we,
  output logic [31:0] epc,
  output logic [3:0]  mcause,
`ifdef PIPE_PERF_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
`endif
  output logic        trap_busy
);

  localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_t           state_q, state_d;
  pend_t            pend_q, pend_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [31:0]      epc_d;
  logic [3:0]       mcause_d;
  logic             load_use;
  logic             mem_freeze;
  logic             trap_req;

  pipeline_ctrl_hazard_detect u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign mem_freeze = dmem_req & ~dmem_ready;
  assign trap_req   = id_syscall | id_break | id_mret;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      pend_q      <= PEND_NONE;
      drain_cnt_q <= '0;
      epc         <= '0;
      mcause      <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      drain_cnt_q <= drain_cnt_d;
      epc         <= epc_d;
      mcause      <= mcause_d;
    end
  end

  // Next-state logic; a memory freeze holds everything in place.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    drain_cnt_d = drain_cnt_q;
    epc_d       = epc;
    mcause_d    = mcause;
    if (!mem_freeze) begin
      case (state_q)
        ST_RUN: begin
          // A taken branch means the ID instruction is wrong-path; a load-use
          // stall retries the same instruction next cycle, so both defer the trap.
          if (!ex_branch_taken && !load_use && trap_req) begin
            state_d     = ST_DRAIN;
            drain_cnt_d = '0;
            pend_d      = pend_of(id_syscall, id_break, id_mret);
            if (id_syscall || id_break) begin
              epc_d    = id_pc;
              mcause_d = id_syscall ? MCAUSE_ECALL : MCAUSE_EBREAK;
            end
          end
        end
        ST_DRAIN: begin
          drain_cnt_d = drain_cnt_q + 1'b1;
          if (drain_cnt_q == DRAIN_LAST) state_d = ST_REDIRECT;
        end
        ST_REDIRECT: begin
          state_d = ST_RUN;
          pend_d  = PEND_NONE;
        end
        default: state_d = ST_RUN;
      endcase
    end
  end

  // Output logic
  always_comb begin
    if_stall  = 1'b0;
    id_stall  = 1'b0;
    ex_stall  = 1'b0;
    mem_stall = 1'b0;
    id_flush  = 1'b0;
    ex_flush  = 1'b0;
    pc_sel    = PC_SEL_SEQ;
    epc_we    = 1'b0;
    trap_busy = (state_q != ST_RUN);
    if (mem_freeze) begin
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_stall  = 1'b1;
      mem_stall = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (ex_branch_taken) begin
            pc_sel   = PC_SEL_BR;
            id_flush = 1'b1;
            ex_flush = 1'b1;
          end else if (load_use) begin
            if_stall = 1'b1;
            id_stall = 1'b1;
            ex_flush = 1'b1;
          end
        end
        ST_DRAIN: begin
          // Hold the trapping instruction's successors while bubbles enter EX.
          if_stall = 1'b1;
          id_stall = 1'b1;
          ex_flush = 1'b1;
        end
        ST_REDIRECT: begin
          id_flush = 1'b1;
          ex_flush = 1'b1;
          if (pend_q == PEND_MRET) begin
            pc_sel = PC_SEL_EPC;
          end else begin
            pc_sel = PC_SEL_TRAP;
            epc_we = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (if_stall) stall_cycles <= stall_cycles + 32'd1;
      if (id_flush) flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int DC = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic [31:0] id_pc;
  logic        id_syscall, id_break, id_mret;
  logic        ex_mem_read, ex_branch_taken, dmem_req, dmem_ready;
  logic        if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_flush;
  logic [1:0]  pc_sel;
  logic        epc_we, trap_busy;
  logic [31:0] epc;
  logic [3:0]  mcause;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  pipeline_ctrl #(.DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_pc(id_pc),
    .id_syscall(id_syscall), .id_break(id_break), .id_mret(id_mret),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .id_flush(id_flush), .ex_flush(ex_flush), .pc_sel(pc_sel), .epc_we(epc_we),
    .epc(epc), .mcause(mcause),
`ifdef PIPE_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
    .trap_busy(trap_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Output bundle: {if,id,ex,mem stall, id_flush, ex_flush, pc_sel[1:0], epc_we, trap_busy}
  function automatic logic [9:0] mk(input bit ifs, ids, exs, mems, idf, exf,
                                    input logic [1:0] pcs, input bit we, busy);
    return {ifs, ids, exs, mems, idf, exf, pcs, we, busy};
  endfunction

  logic [9:0] V_ZERO, V_LU, V_BR, V_FRZ, V_FRZ_BUSY, V_DRAIN, V_TRAP, V_EPC;

  function automatic logic [9:0] outs();
    return {if_stall, id_stall, ex_stall, mem_stall, id_flush, ex_flush, pc_sel, epc_we, trap_busy};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0; id_pc = 0;
    id_syscall = 0; id_break = 0; id_mret = 0;
    ex_mem_read = 0; ex_branch_taken = 0; dmem_req = 0; dmem_ready = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic mr, br, sys, brk, mret, dreq, drdy;
    logic [9:0] exp;
  } vec_t;

  function automatic vec_t mkv(input logic [4:0] rs1, rs2, rd,
                               input bit mr, br, sys, brk, mret, dreq, drdy,
                               input logic [9:0] exp);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.mr = mr; v.br = br;
    v.sys = sys; v.brk = brk; v.mret = mret; v.dreq = dreq; v.drdy = drdy;
    v.exp = exp;
    return v;
  endfunction

  // Trap sequence from RUN: accept, DC drain cycles, redirect, back to idle.
  task automatic run_syscall(input logic [31:0] pc);
    next_cycle(); idle_inputs(); id_syscall = 1; id_pc = pc;
    sample(); chk("ecall_accept", {22'd0, outs()}, {22'd0, V_ZERO});
    next_cycle(); idle_inputs();
    for (int i = 0; i < DC; i++) begin
      sample(); chk("ecall_drain", {22'd0, outs()}, {22'd0, V_DRAIN});
      next_cycle();
    end
    sample();
    chk("ecall_redirect", {22'd0, outs()}, {22'd0, V_TRAP});
    chk("ecall_epc", epc, pc);
    chk("ecall_mcause", {28'd0, mcause}, 32'd11);
    next_cycle();
    sample(); chk("ecall_after", {22'd0, outs()}, {22'd0, V_ZERO});
  endtask

  vec_t tbl[12];

  initial begin
    V_ZERO     = mk(0,0,0,0,0,0,2'b00,0,0);
    V_LU       = mk(1,1,0,0,0,1,2'b00,0,0);
    V_BR       = mk(0,0,0,0,1,1,2'b01,0,0);
    V_FRZ      = mk(1,1,1,1,0,0,2'b00,0,0);
    V_FRZ_BUSY = mk(1,1,1,1,0,0,2'b00,0,1);
    V_DRAIN    = mk(1,1,0,0,0,1,2'b00,0,1);
    V_TRAP     = mk(0,0,0,0,1,1,2'b10,1,1);
    V_EPC      = mk(0,0,0,0,1,1,2'b11,0,1);

    //              rs1 rs2 rd  mr br sys brk mret dreq drdy exp
    tbl[0]  = mkv(0, 0, 0,  0, 0, 0, 0, 0, 0, 0, V_ZERO);
    tbl[1]  = mkv(1, 5, 5,  1, 0, 0, 0, 0, 0, 0, V_LU);
    tbl[2]  = mkv(1, 5, 5,  0, 0, 0, 0, 0, 0, 0, V_ZERO);
    tbl[3]  = mkv(0, 0, 0,  1, 0, 0, 0, 0, 0, 0, V_ZERO);
    tbl[4]  = mkv(7, 2, 7,  1, 0, 0, 0, 0, 0, 0, V_LU);
    tbl[5]  = mkv(6, 8, 7,  1, 0, 0, 0, 0, 0, 0, V_ZERO);
    tbl[6]  = mkv(0, 0, 0,  0, 1, 0, 1, 0, 0, 0, V_BR);
    tbl[7]  = mkv(3, 0, 3,  1, 1, 0, 0, 0, 0, 0, V_BR);
    tbl[8]  = mkv(0, 0, 0,  0, 1, 1, 0, 1, 0, 0, V_BR);
    tbl[9]  = mkv(0, 0, 0,  0, 0, 1, 0, 0, 1, 0, V_FRZ);
    tbl[10] = mkv(4, 2, 2,  1, 0, 0, 0, 0, 1, 1, V_LU);
    tbl[11] = mkv(0, 0, 0,  0, 1, 0, 0, 0, 1, 0, V_FRZ);

    // ---------------- reset ----------------
    idle_inputs();
    rst = 1'b1;
    #1;
    chk("reset_outs", {22'd0, outs()}, {22'd0, V_ZERO});
    chk("reset_epc", epc, 32'd0);
    chk("reset_mcause", {28'd0, mcause}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // ---------------- load-use then rd=0 ----------------
    next_cycle(); ex_mem_read = 1; ex_rd = 5; id_rs2 = 5;
    sample(); chk("lu_stall", {22'd0, outs()}, {22'd0, V_LU});
    next_cycle(); ex_mem_read = 0;
    sample(); chk("lu_clear", {22'd0, outs()}, {22'd0, V_ZERO});
    next_cycle(); ex_mem_read = 1; ex_rd = 0; id_rs2 = 0; id_rs1 = 0;
    sample(); chk("lu_rd0", {22'd0, outs()}, {22'd0, V_ZERO});

    // ---------------- ecall ----------------
    run_syscall(32'h100);
`ifdef PIPE_PERF_CNT_EN
    chk("perf_stall_cycles", stall_cycles, 32'd4);
    chk("perf_flush_events", flush_events, 32'd1);
`endif

    // ---------------- table vectors (all leave FSM in RUN) ----------------
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      idle_inputs();
      id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2; ex_rd = tbl[i].rd;
      ex_mem_read = tbl[i].mr; ex_branch_taken = tbl[i].br;
      id_syscall = tbl[i].sys; id_break = tbl[i].brk; id_mret = tbl[i].mret;
      dmem_req = tbl[i].dreq; dmem_ready = tbl[i].drdy; id_pc = 32'h400 + 32'(i);
      sample();
      chk($sformatf("table[%0d]", i), {22'd0, outs()}, {22'd0, tbl[i].exp});
    end
    next_cycle(); idle_inputs();
    sample();
    chk("after_table_idle", {22'd0, outs()}, {22'd0, V_ZERO});
    chk("branch_kept_epc", epc, 32'h100);

    // ---------------- mret with 4 frozen drain cycles ----------------
    begin
      int k;
      int found;
      next_cycle(); idle_inputs(); id_mret = 1; id_pc = 32'h999;
      sample(); chk("mret_accept", {22'd0, outs()}, {22'd0, V_ZERO});
      k = 0;
      found = -1;
      while (found < 0 && k < 20) begin
        k++;
        next_cycle(); idle_inputs();
        if (k >= 2 && k <= 5) begin
          dmem_req = 1; dmem_ready = 0;
        end
        sample();
        if (k >= 2 && k <= 5)
          chk("mret_freeze", {22'd0, outs()}, {22'd0, V_FRZ_BUSY});
        if (pc_sel == 2'b11) found = k;
      end
      chk("mret_redirect_delay", found, DC + 1 + 4);
      chk("mret_redirect_outs", {22'd0, outs()}, {22'd0, V_EPC});
      chk("mret_epc_hold", epc, 32'h100);
      chk("mret_mcause_hold", {28'd0, mcause}, 32'd11);
      next_cycle(); idle_inputs();
      sample(); chk("mret_after", {22'd0, outs()}, {22'd0, V_ZERO});
    end

    // ---------------- randomized vs reference model ----------------
    begin
      int          m_wait = 0;       // unfrozen drain cycles still owed
      bit          m_redirect = 0;
      bit          m_mret = 0;
      logic [31:0] m_epc = 32'h100;
      logic [3:0]  m_cause = 4'd11;
      for (int c = 0; c < 3000; c++) begin
        logic [9:0]  e;
        int          n_wait;
        bit          n_redirect, n_mret, frz, lu, trap;
        logic [31:0] n_epc;
        logic [3:0]  n_cause;
        next_cycle();
        id_rs1 = 5'($urandom_range(0, 3));
        id_rs2 = 5'($urandom_range(0, 3));
        ex_rd  = 5'($urandom_range(0, 3));
        ex_mem_read     = 1'($urandom_range(0, 1));
        ex_branch_taken = ($urandom_range(0, 7) == 0);
        id_syscall      = ($urandom_range(0, 15) == 0);
        id_break        = ($urandom_range(0, 15) == 0);
        id_mret         = ($urandom_range(0, 15) == 0);
        dmem_req        = ($urandom_range(0, 3) == 0);
        dmem_ready      = 1'($urandom_range(0, 1));
        id_pc           = $urandom & 32'hffff_fffc;
        sample();
        n_wait = m_wait; n_redirect = m_redirect; n_mret = m_mret;
        n_epc = m_epc; n_cause = m_cause;
        frz  = dmem_req && !dmem_ready;
        lu   = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
        trap = id_syscall || id_break || id_mret;
        if (frz) begin
          e = (m_wait > 0 || m_redirect) ? V_FRZ_BUSY : V_FRZ;
        end else if (m_redirect) begin
          e = m_mret ? V_EPC : V_TRAP;
          n_redirect = 0;
        end else if (m_wait > 0) begin
          e = V_DRAIN;
          n_wait = m_wait - 1;
          if (n_wait == 0) n_redirect = 1;
        end else if (ex_branch_taken) begin
          e = V_BR;
        end else if (lu) begin
          e = V_LU;
        end else if (trap) begin
          e = V_ZERO;
          n_wait = DC;
          n_mret = !(id_syscall || id_break);
          if (!n_mret) begin
            n_epc = id_pc;
            n_cause = id_syscall ? 4'd11 : 4'd3;
          end
        end else begin
          e = V_ZERO;
        end
        chk("rand_outs", {22'd0, outs()}, {22'd0, e});
        chk("rand_epc", epc, m_epc);
        chk("rand_mcause", {28'd0, mcause}, {28'd0, m_cause});
        m_wait = n_wait; m_redirect = n_redirect; m_mret = n_mret;
        m_epc = n_epc; m_cause = n_cause;
      end
      // Let any in-flight trap finish before the reset test.
      for (int c = 0; c < 12; c++) begin
        next_cycle(); idle_inputs();
      end
    end

    // ---------------- async reset mid-DRAIN ----------------
    next_cycle(); idle_inputs(); id_syscall = 1; id_pc = 32'h200;
    next_cycle(); idle_inputs();
    sample(); chk("rst_pre_drain", {22'd0, outs()}, {22'd0, V_DRAIN});
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_outs", {22'd0, outs()}, {22'd0, V_ZERO});
    chk("rst_mid_epc", epc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      next_cycle(); idle_inputs();
      sample(); chk("rst_no_redirect", {22'd0, outs()}, {22'd0, V_ZERO});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global guard so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
